axi_fifo_writer: RTL

- Upstream write-request source for axi_arbiter; one instance sits on each arbiter write port.
- Accepts a simple valid/ready stream of (addr, data, strb) write requests and buffers them in a small FIFO.
- Issues each request as a single-beat AXI-lite write with AW and W presented together.
- Tracks outstanding B responses, throttles issue at a configurable limit, and flags error responses.

---
 rtl/axi_fifo_writer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axi_fifo_writer.sv
// Buffers (addr, data, strb) write requests in a small FIFO and issues each one as a
// single-beat AXI-lite write with AW and W presented together; tracks outstanding B beats.
module axi_fifo_writer #(
  parameter  int AXI_ADDR_WIDTH  = 20,
  parameter  int AXI_DATA_WIDTH  = 16,
  parameter  int FIFO_DEPTH      = 4,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int AXI_STRB_WIDTH  = (AXI_DATA_WIDTH + 7) / 8,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      axi_clk,
  input  logic                      axi_resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] req_data,
  input  logic [AXI_STRB_WIDTH-1:0] req_strb,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0] axi_wstrb,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  output logic [OUT_W-1:0]          outstanding,
  output logic                      err,
  output logic                      idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + AXI_STRB_WIDTH;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ENT_W-1:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W:0]            r_wptr;
  logic [PTR_W:0]            r_rptr;
  logic [PTR_W:0]            w_count;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_done;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_inc;
  logic                      w_dec;
  logic [ENT_W-1:0]          w_head;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [AXI_STRB_WIDTH-1:0] r_wstrb;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic [OUT_W-1:0]          r_outstanding;
  logic                      r_err;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_empty = (w_count == '0);
  assign w_push  = req_valid && !w_full;
  assign w_head  = r_mem[r_rptr[PTR_W-1:0]];
  assign w_aw_hs = r_awvalid && axi_awready;
  assign w_w_hs  = r_wvalid && axi_wready;
  assign w_inc   = w_done;
  assign w_dec   = axi_bvalid && (r_outstanding != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && (r_outstanding < OUT_W'(MAX_OUTSTANDING))) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if ((!r_awvalid || axi_awready) && (!r_wvalid || axi_wready)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge axi_clk) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= {req_addr, req_data, req_strb};
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_awaddr      <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W + 1)'(1);
      if (w_pop) begin
        r_rptr                        <= r_rptr + (PTR_W + 1)'(1);
        {r_awaddr, r_wdata, r_wstrb}  <= w_head;
        r_awvalid                     <= 1'b1;
        r_wvalid                      <= 1'b1;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
      end
      // A B beat with nothing outstanding is dropped (count saturates) and flagged.
      if (w_inc && !w_dec)      r_outstanding <= r_outstanding + OUT_W'(1);
      else if (!w_inc && w_dec) r_outstanding <= r_outstanding - OUT_W'(1);
      if (axi_bvalid && ((axi_bresp != 2'b00) || (r_outstanding == '0))) r_err <= 1'b1;
    end
  end

  assign req_ready   = !w_full;
  assign axi_awaddr  = r_awaddr;
  assign axi_awvalid = r_awvalid;
  assign axi_wdata   = r_wdata;
  assign axi_wstrb   = r_wstrb;
  assign axi_wvalid  = r_wvalid;
  assign axi_bready  = axi_resetn;
  assign outstanding = r_outstanding;
  assign err         = r_err;
  assign idle        = w_empty && (r_state == S_IDLE) && (r_outstanding == '0);

endmodule
